// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: load/store size codes, FSM states, opcodes.
package mem_pkg;

  typedef enum logic [2:0] {
    SLT_LB  = 3'b000,
    SLT_LH  = 3'b001,
    SLT_LW  = 3'b010,
    SLT_LD  = 3'b011,
    SLT_LBU = 3'b100,
    SLT_LHU = 3'b101,
    SLT_LWU = 3'b110
  } slt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RSP,
    ST_DROP
  } state_e;

  typedef enum logic [6:0] {
    OPC_LOAD  = 7'b0000011,
    OPC_STORE = 7'b0100011
  } opcode_e;

endpackage

// File: rtl/ld_align.sv
// Load data lane select and sign/zero extension.
module ld_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LANE_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]   rdata,
  input  logic [LANE_W-1:0] lane,
  input  logic [2:0]        slt_sl,
  output logic [XLEN-1:0]   ld_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    case (slt_sl)
      SLT_LB:  ld_data = XLEN'($signed(shifted[7:0]));
      SLT_LH:  ld_data = XLEN'($signed(shifted[15:0]));
      SLT_LW:  ld_data = XLEN'($signed(shifted[31:0]));
      SLT_LBU: ld_data = XLEN'(shifted[7:0]);
      SLT_LHU: ld_data = XLEN'(shifted[15:0]);
      SLT_LWU: ld_data = XLEN'(shifted[31:0]);
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with valid/ready upstream, req/gnt/rvalid data-memory bus,
// and a MEM/WB register that pulses o_wb_valid for one cycle per retired op.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NLANE = XLEN / 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_mem_valid,
  output logic             o_mem_ready,
  input  logic [31:0]      i_mem_inst,
  input  logic [XLEN-1:0]  i_mem_pc,
  input  logic [XLEN-1:0]  i_mem_alu_data,
  input  logic [XLEN-1:0]  i_mem_rs2_data,
  input  logic             i_mem_lsu_wren,
  input  logic             i_mem_lsu_rden,
  input  logic [2:0]       i_mem_slt_sl,
  input  logic [1:0]       i_mem_wb_sel,
  input  logic             i_mem_rd_wren,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [XLEN-1:0]  o_dmem_addr,
  output logic [XLEN-1:0]  o_dmem_wdata,
  output logic [NLANE-1:0] o_dmem_be,
  input  logic             i_dmem_gnt,
  input  logic             i_dmem_rvalid,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  output logic             o_wb_valid,
  output logic             o_wb_rd_wren,
  output logic             o_wb_err,
  output logic [1:0]       o_wb_wb_sel,
  output logic [31:0]      o_wb_inst,
  output logic [XLEN-1:0]  o_wb_pc_add4,
  output logic [XLEN-1:0]  o_wb_alu_data,
  output logic [XLEN-1:0]  o_wb_ld_data,
  output logic [XLEN-1:0]  o_wb_pc,
  output logic [4:0]       o_mem_rd_addr_fwd,
  output logic             o_mem_fwd_vld,
  output logic             o_mem_stall
);

  localparam int LANE_W = $clog2(NLANE);

  state_e state, state_n;

  logic [31:0]      hold_inst;
  logic [XLEN-1:0]  hold_pc, hold_addr, hold_wdata;
  logic [NLANE-1:0] hold_be;
  logic             hold_we, hold_rden, hold_rd_wren;
  logic [2:0]       hold_slt;
  logic [1:0]       hold_wb_sel;

  logic             hold_en, wb_write, wb_from_hold, wb_err_n, wb_ld;
  logic [1:0]       req_size;
  logic [LANE_W-1:0] req_lane;
  logic             misaligned, illegal;
  logic [NLANE-1:0] be_n;
  logic [XLEN-1:0]  wdata_n, ld_aligned;

  logic [31:0]      src_inst;
  logic [XLEN-1:0]  src_pc, src_alu;
  logic [1:0]       src_wb_sel;
  logic             src_rd_wren;

  ld_align #(.XLEN(XLEN), .LANE_W(LANE_W)) u_ld_align (
    .rdata   (i_dmem_rdata),
    .lane    (hold_addr[LANE_W-1:0]),
    .slt_sl  (hold_slt),
    .ld_data (ld_aligned)
  );

  // Request decode: unsigned-load codes share the size field with their signed twins.
  always_comb begin
    req_size = i_mem_slt_sl[1:0];
    req_lane = i_mem_alu_data[LANE_W-1:0];
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = i_mem_alu_data[0];
      2'd2:    misaligned = |i_mem_alu_data[1:0];
      default: misaligned = |i_mem_alu_data[2:0];
    endcase
    illegal = (XLEN == 32) && ((req_size == 2'd3) || (i_mem_slt_sl == SLT_LWU));
    case (req_size)
      2'd0:    be_n = NLANE'(1) << req_lane;
      2'd1:    be_n = NLANE'(3) << req_lane;
      2'd2:    be_n = NLANE'(15) << req_lane;
      default: be_n = '1;
    endcase
    wdata_n = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      case (req_size)
        2'd0:    wdata_n[8*i +: 8] = i_mem_rs2_data[7:0];
        2'd1:    wdata_n[8*i +: 8] = i_mem_rs2_data[8*(i%2) +: 8];
        2'd2:    wdata_n[8*i +: 8] = i_mem_rs2_data[8*(i%4) +: 8];
        default: wdata_n[8*i +: 8] = i_mem_rs2_data[8*i +: 8];
      endcase
    end
  end

  always_comb begin
    state_n      = state;
    hold_en      = 1'b0;
    wb_write     = 1'b0;
    wb_from_hold = 1'b0;
    wb_err_n     = 1'b0;
    wb_ld        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_mem_valid && !i_flush) begin
          if (i_mem_lsu_rden || i_mem_lsu_wren) begin
            if (misaligned || illegal) begin
              wb_write = 1'b1;
              wb_err_n = 1'b1;
            end else begin
              hold_en = 1'b1;
              state_n = ST_REQ;
            end
          end else begin
            wb_write = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (i_dmem_gnt) begin
          // A granted store expects no response, so a flush at grant cannot wait in DROP.
          if (i_flush) begin
            state_n = (!hold_rden || i_dmem_rvalid) ? ST_IDLE : ST_DROP;
          end else if (!hold_rden || i_dmem_rvalid) begin
            wb_write     = 1'b1;
            wb_from_hold = 1'b1;
            wb_ld        = hold_rden;
            state_n      = ST_IDLE;
          end else begin
            state_n = ST_RSP;
          end
        end else if (i_flush) begin
          state_n = ST_IDLE;
        end
      end
      ST_RSP: begin
        if (i_flush) begin
          state_n = i_dmem_rvalid ? ST_IDLE : ST_DROP;
        end else if (i_dmem_rvalid) begin
          wb_write     = 1'b1;
          wb_from_hold = 1'b1;
          wb_ld        = 1'b1;
          state_n      = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (i_dmem_rvalid) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    src_inst    = wb_from_hold ? hold_inst    : i_mem_inst;
    src_pc      = wb_from_hold ? hold_pc      : i_mem_pc;
    src_alu     = wb_from_hold ? hold_addr    : i_mem_alu_data;
    src_wb_sel  = wb_from_hold ? hold_wb_sel  : i_mem_wb_sel;
    src_rd_wren = wb_from_hold ? hold_rd_wren : i_mem_rd_wren;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= ST_IDLE;
      hold_inst    <= '0;
      hold_pc      <= '0;
      hold_addr    <= '0;
      hold_wdata   <= '0;
      hold_be      <= '0;
      hold_we      <= 1'b0;
      hold_rden    <= 1'b0;
      hold_rd_wren <= 1'b0;
      hold_slt     <= '0;
      hold_wb_sel  <= '0;
      o_wb_valid    <= 1'b0;
      o_wb_rd_wren  <= 1'b0;
      o_wb_err      <= 1'b0;
      o_wb_wb_sel   <= '0;
      o_wb_inst     <= '0;
      o_wb_pc       <= '0;
      o_wb_pc_add4  <= '0;
      o_wb_alu_data <= '0;
      o_wb_ld_data  <= '0;
    end else begin
      state <= state_n;
      if (hold_en) begin
        hold_inst    <= i_mem_inst;
        hold_pc      <= i_mem_pc;
        hold_addr    <= i_mem_alu_data;
        hold_wdata   <= wdata_n;
        hold_be      <= be_n;
        hold_we      <= i_mem_lsu_wren;
        hold_rden    <= i_mem_lsu_rden;
        hold_rd_wren <= i_mem_rd_wren;
        hold_slt     <= i_mem_slt_sl;
        hold_wb_sel  <= i_mem_wb_sel;
      end
      o_wb_valid   <= wb_write;
      o_wb_rd_wren <= wb_write && !wb_err_n && src_rd_wren;
      o_wb_err     <= wb_write && wb_err_n;
      if (wb_write) begin
        o_wb_wb_sel   <= src_wb_sel;
        o_wb_inst     <= src_inst;
        o_wb_pc       <= src_pc;
        o_wb_pc_add4  <= src_pc + XLEN'(4);
        o_wb_alu_data <= src_alu;
        o_wb_ld_data  <= wb_ld ? ld_aligned : '0;
      end
    end
  end

  always_comb begin
    o_mem_ready       = (state == ST_IDLE);
    o_mem_stall       = !o_mem_ready;
    o_dmem_req        = (state == ST_REQ);
    o_dmem_we         = hold_we;
    o_dmem_addr       = hold_addr;
    o_dmem_wdata      = hold_wdata;
    o_dmem_be         = hold_be;
    o_mem_rd_addr_fwd = (state == ST_IDLE) ? i_mem_inst[11:7] : hold_inst[11:7];
    o_mem_fwd_vld     = (state == ST_IDLE) && i_mem_valid && i_mem_rd_wren && !i_mem_lsu_rden;
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs (XLEN=32).
module tb_mem_stage_hs;

  localparam int XLEN  = 32;
  localparam int NLANE = 4;

  logic             i_clk = 1'b0;
  logic             i_reset_n, i_flush, i_mem_valid, o_mem_ready;
  logic [31:0]      i_mem_inst;
  logic [XLEN-1:0]  i_mem_pc, i_mem_alu_data, i_mem_rs2_data;
  logic             i_mem_lsu_wren, i_mem_lsu_rden, i_mem_rd_wren;
  logic [2:0]       i_mem_slt_sl;
  logic [1:0]       i_mem_wb_sel;
  logic             o_dmem_req, o_dmem_we;
  logic [XLEN-1:0]  o_dmem_addr, o_dmem_wdata;
  logic [NLANE-1:0] o_dmem_be;
  logic             i_dmem_gnt, i_dmem_rvalid;
  logic [XLEN-1:0]  i_dmem_rdata;
  logic             o_wb_valid, o_wb_rd_wren, o_wb_err;
  logic [1:0]       o_wb_wb_sel;
  logic [31:0]      o_wb_inst;
  logic [XLEN-1:0]  o_wb_pc_add4, o_wb_alu_data, o_wb_ld_data, o_wb_pc;
  logic [4:0]       o_mem_rd_addr_fwd;
  logic             o_mem_fwd_vld, o_mem_stall;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  mem_stage_hs #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
    .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
    .i_mem_inst(i_mem_inst), .i_mem_pc(i_mem_pc), .i_mem_alu_data(i_mem_alu_data),
    .i_mem_rs2_data(i_mem_rs2_data), .i_mem_lsu_wren(i_mem_lsu_wren),
    .i_mem_lsu_rden(i_mem_lsu_rden), .i_mem_slt_sl(i_mem_slt_sl),
    .i_mem_wb_sel(i_mem_wb_sel), .i_mem_rd_wren(i_mem_rd_wren),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_rd_wren(o_wb_rd_wren), .o_wb_err(o_wb_err),
    .o_wb_wb_sel(o_wb_wb_sel), .o_wb_inst(o_wb_inst), .o_wb_pc_add4(o_wb_pc_add4),
    .o_wb_alu_data(o_wb_alu_data), .o_wb_ld_data(o_wb_ld_data), .o_wb_pc(o_wb_pc),
    .o_mem_rd_addr_fwd(o_mem_rd_addr_fwd), .o_mem_fwd_vld(o_mem_fwd_vld),
    .o_mem_stall(o_mem_stall)
  );

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle;
    i_flush = 1'b0; i_mem_valid = 1'b0; i_mem_inst = '0; i_mem_pc = '0;
    i_mem_alu_data = '0; i_mem_rs2_data = '0; i_mem_lsu_wren = 1'b0;
    i_mem_lsu_rden = 1'b0; i_mem_slt_sl = '0; i_mem_wb_sel = '0;
    i_mem_rd_wren = 1'b0; i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
  endtask

  task automatic drive_op(input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic wr, input logic rd, input logic [2:0] slt,
                          input logic rdw);
    i_mem_valid = 1'b1; i_mem_inst = inst; i_mem_pc = pc; i_mem_alu_data = addr;
    i_mem_rs2_data = rs2; i_mem_lsu_wren = wr; i_mem_lsu_rden = rd;
    i_mem_slt_sl = slt; i_mem_rd_wren = rdw; i_mem_wb_sel = rd ? 2'd1 : 2'd0;
  endtask

  task automatic test_reset;
    i_reset_n = 1'b0;
    drive_op(32'h00500093, 32'h10, 32'h77, 32'h0, 1'b0, 1'b0, 3'b010, 1'b1);
    tick; tick;
    checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL reset wb_valid: got %b exp 0", o_wb_valid); end
    checks++; if (o_wb_alu_data !== 32'h0) begin errors++; $display("FAIL reset wb_alu: got %h exp 0", o_wb_alu_data); end
    checks++; if (o_dmem_req !== 1'b0) begin errors++; $display("FAIL reset req: got %b exp 0", o_dmem_req); end
    checks++; if (o_wb_err !== 1'b0) begin errors++; $display("FAIL reset err: got %b exp 0", o_wb_err); end
    checks++; if (o_mem_ready !== 1'b1 || o_mem_stall !== 1'b0) begin errors++; $display("FAIL reset ready/stall: got %b/%b exp 1/0", o_mem_ready, o_mem_stall); end
    drive_idle;
    i_reset_n = 1'b1;
    tick;
  endtask

  task automatic test_alu;
    drive_op(32'h00500093, 32'h100, 32'h1234, 32'h0, 1'b0, 1'b0, 3'b010, 1'b1);
    #1;
    checks++; if (o_mem_fwd_vld !== 1'b1) begin errors++; $display("FAIL alu fwd_vld: got %b exp 1", o_mem_fwd_vld); end
    checks++; if (o_mem_rd_addr_fwd !== 5'd1) begin errors++; $display("FAIL alu fwd_addr: got %0d exp 1", o_mem_rd_addr_fwd); end
    tick;
    drive_idle;
    checks++; if (o_wb_valid !== 1'b1) begin errors++; $display("FAIL alu wb_valid: got %b exp 1", o_wb_valid); end
    checks++; if (o_wb_alu_data !== 32'h1234) begin errors++; $display("FAIL alu wb_alu: got %h exp 1234", o_wb_alu_data); end
    checks++; if (o_wb_pc_add4 !== 32'h104) begin errors++; $display("FAIL alu pc_add4: got %h exp 104", o_wb_pc_add4); end
    checks++; if (o_wb_pc !== 32'h100 || o_wb_inst !== 32'h00500093) begin errors++; $display("FAIL alu pc/inst: got %h/%h exp 100/00500093", o_wb_pc, o_wb_inst); end
    checks++; if (o_wb_rd_wren !== 1'b1 || o_wb_err !== 1'b0) begin errors++; $display("FAIL alu rd_wren/err: got %b/%b exp 1/0", o_wb_rd_wren, o_wb_err); end
    tick;
    checks++; if (o_wb_valid !== 1'b0 || o_wb_rd_wren !== 1'b0) begin errors++; $display("FAIL alu pulse: got %b/%b exp 0/0", o_wb_valid, o_wb_rd_wren); end
    drive_op(32'h00500093, 32'hFFFF_FFFC, 32'h1, 32'h0, 1'b0, 1'b0, 3'b010, 1'b1);
    tick;
    drive_idle;
    checks++; if (o_wb_pc_add4 !== 32'h0) begin errors++; $display("FAIL pc wrap: got %h exp 0", o_wb_pc_add4); end
  endtask

  task automatic test_store;
    drive_op(32'h00000023, 32'h200, 32'h103, 32'hAB, 1'b1, 1'b0, 3'b000, 1'b0);
    #1;
    checks++; if (o_mem_ready !== 1'b1) begin errors++; $display("FAIL sb accept ready: got %b exp 1", o_mem_ready); end
    tick;
    drive_idle;
    i_mem_rs2_data = 32'h55; i_mem_alu_data = 32'h999;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) i_dmem_gnt = 1'b1;
      #1;
      checks++; if (o_dmem_req !== 1'b1 || o_dmem_we !== 1'b1) begin errors++; $display("FAIL sb req/we c%0d: got %b/%b exp 1/1", c, o_dmem_req, o_dmem_we); end
      checks++; if (o_dmem_be !== 4'b1000) begin errors++; $display("FAIL sb be c%0d: got %b exp 1000", c, o_dmem_be); end
      checks++; if (o_dmem_wdata !== 32'hABABABAB || o_dmem_addr !== 32'h103) begin errors++; $display("FAIL sb wdata/addr c%0d: got %h/%h exp ABABABAB/103", c, o_dmem_wdata, o_dmem_addr); end
      checks++; if (o_mem_ready !== 1'b0 || o_mem_stall !== 1'b1) begin errors++; $display("FAIL sb ready/stall c%0d: got %b/%b exp 0/1", c, o_mem_ready, o_mem_stall); end
      tick;
    end
    i_dmem_gnt = 1'b0;
    checks++; if (o_wb_valid !== 1'b1 || o_mem_ready !== 1'b1) begin errors++; $display("FAIL sb wb/ready: got %b/%b exp 1/1", o_wb_valid, o_mem_ready); end
    checks++; if (o_dmem_req !== 1'b0 || o_wb_rd_wren !== 1'b0) begin errors++; $display("FAIL sb req/rd_wren after: got %b/%b exp 0/0", o_dmem_req, o_wb_rd_wren); end
    drive_op(32'h00001023, 32'h204, 32'h102, 32'h1234BEEF, 1'b1, 1'b0, 3'b001, 1'b0);
    tick;
    drive_idle;
    checks++; if (o_dmem_be !== 4'b1100 || o_dmem_wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh be/wdata: got %b/%h exp 1100/BEEFBEEF", o_dmem_be, o_dmem_wdata); end
    i_dmem_gnt = 1'b1;
    tick;
    i_dmem_gnt = 1'b0;
    checks++; if (o_wb_valid !== 1'b1) begin errors++; $display("FAIL sh wb_valid: got %b exp 1", o_wb_valid); end
  endtask

  task automatic do_load(input logic [2:0] slt, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp);
    drive_op(32'h00000283, 32'h300, addr, 32'h0, 1'b0, 1'b1, slt, 1'b1);
    #1;
    checks++; if (o_mem_fwd_vld !== 1'b0 || o_mem_rd_addr_fwd !== 5'd5) begin errors++; $display("FAIL ld%0d fwd: got %b/%0d exp 0/5", slt, o_mem_fwd_vld, o_mem_rd_addr_fwd); end
    tick;
    drive_idle;
    checks++; if (o_dmem_req !== 1'b1 || o_dmem_we !== 1'b0 || o_dmem_be !== exp_be) begin errors++; $display("FAIL ld%0d req/we/be: got %b/%b/%b exp 1/0/%b", slt, o_dmem_req, o_dmem_we, o_dmem_be, exp_be); end
    checks++; if (o_mem_rd_addr_fwd !== 5'd5) begin errors++; $display("FAIL ld%0d held fwd_addr: got %0d exp 5", slt, o_mem_rd_addr_fwd); end
    i_dmem_gnt = 1'b1;
    tick;
    i_dmem_gnt = 1'b0;
    checks++; if (o_dmem_req !== 1'b0 || o_mem_ready !== 1'b0) begin errors++; $display("FAIL ld%0d rsp wait: got %b/%b exp 0/0", slt, o_dmem_req, o_mem_ready); end
    i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
    tick;
    i_dmem_rvalid = 1'b0;
    checks++; if (o_wb_valid !== 1'b1 || o_wb_rd_wren !== 1'b1) begin errors++; $display("FAIL ld%0d wb_valid/rd_wren: got %b/%b exp 1/1", slt, o_wb_valid, o_wb_rd_wren); end
    checks++; if (o_wb_ld_data !== exp) begin errors++; $display("FAIL ld%0d data: got %h exp %h", slt, o_wb_ld_data, exp); end
  endtask

  task automatic test_loads;
    do_load(3'b000, 32'h102, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80);
    do_load(3'b100, 32'h102, 32'h0080_0000, 4'b0100, 32'h0000_0080);
    do_load(3'b000, 32'h103, 32'h7F00_0000, 4'b1000, 32'h0000_007F);
    do_load(3'b001, 32'h102, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
    do_load(3'b101, 32'h102, 32'h8001_0000, 4'b1100, 32'h0000_8001);
    do_load(3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
  endtask

  task automatic test_same_cycle;
    drive_op(32'h00000283, 32'h400, 32'h104, 32'h0, 1'b0, 1'b1, 3'b010, 1'b1);
    tick;
    drive_idle;
    i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
    tick;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
    checks++; if (o_wb_valid !== 1'b1 || o_wb_ld_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL gnt+rvalid: got %b/%h exp 1/CAFEF00D", o_wb_valid, o_wb_ld_data); end
    checks++; if (o_mem_ready !== 1'b1) begin errors++; $display("FAIL gnt+rvalid ready: got %b exp 1", o_mem_ready); end
  endtask

  task automatic do_misaligned(input logic [2:0] slt, input logic [31:0] addr, input logic wr);
    drive_op(32'h00000283, 32'h500, addr, 32'h0, wr, !wr, slt, 1'b1);
    #1;
    checks++; if (o_dmem_req !== 1'b0) begin errors++; $display("FAIL mis%0d@%h req pre: got %b exp 0", slt, addr, o_dmem_req); end
    tick;
    drive_idle;
    checks++; if (o_dmem_req !== 1'b0 || o_mem_ready !== 1'b1) begin errors++; $display("FAIL mis%0d@%h req/ready: got %b/%b exp 0/1", slt, addr, o_dmem_req, o_mem_ready); end
    checks++; if (o_wb_valid !== 1'b1 || o_wb_err !== 1'b1 || o_wb_rd_wren !== 1'b0) begin errors++; $display("FAIL mis%0d@%h valid/err/rd_wren: got %b/%b/%b exp 1/1/0", slt, addr, o_wb_valid, o_wb_err, o_wb_rd_wren); end
    tick;
    checks++; if (o_wb_err !== 1'b0) begin errors++; $display("FAIL mis%0d@%h err clear: got %b exp 0", slt, addr, o_wb_err); end
  endtask

  task automatic test_misaligned;
    do_misaligned(3'b010, 32'h102, 1'b0);
    do_misaligned(3'b001, 32'h103, 1'b0);
    do_misaligned(3'b011, 32'h100, 1'b0);
    do_misaligned(3'b110, 32'h100, 1'b0);
    do_misaligned(3'b001, 32'h101, 1'b1);
  endtask

  task automatic test_flush;
    drive_op(32'h00500093, 32'h600, 32'h11, 32'h0, 1'b0, 1'b0, 3'b010, 1'b1);
    tick;
    i_flush = 1'b1; i_mem_alu_data = 32'h22;
    tick;
    drive_idle;
    checks++; if (o_wb_valid !== 1'b0 || o_mem_ready !== 1'b1) begin errors++; $display("FAIL flush idle: got %b/%b exp 0/1", o_wb_valid, o_mem_ready); end
    drive_op(32'h00000283, 32'h700, 32'h100, 32'h0, 1'b0, 1'b1, 3'b010, 1'b1);
    tick;
    drive_idle;
    i_flush = 1'b1;
    tick;
    i_flush = 1'b0;
    checks++; if (o_dmem_req !== 1'b0 || o_mem_ready !== 1'b1 || o_wb_valid !== 1'b0) begin errors++; $display("FAIL flush req: got %b/%b/%b exp 0/1/0", o_dmem_req, o_mem_ready, o_wb_valid); end
    drive_op(32'h00000283, 32'h800, 32'h108, 32'h0, 1'b0, 1'b1, 3'b010, 1'b1);
    tick;
    drive_idle;
    i_dmem_gnt = 1'b1;
    tick;
    i_dmem_gnt = 1'b0; i_flush = 1'b1;
    tick;
    i_flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++; if (o_mem_ready !== 1'b0 || o_dmem_req !== 1'b0) begin errors++; $display("FAIL drop wait c%0d: got %b/%b exp 0/0", c, o_mem_ready, o_dmem_req); end
      tick;
    end
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1111_1111;
    tick;
    i_dmem_rvalid = 1'b0;
    checks++; if (o_wb_valid !== 1'b0 || o_mem_ready !== 1'b1) begin errors++; $display("FAIL drop done: got %b/%b exp 0/1", o_wb_valid, o_mem_ready); end
    drive_op(32'h00000283, 32'h900, 32'h10C, 32'h0, 1'b0, 1'b1, 3'b010, 1'b1);
    tick;
    drive_idle;
    i_dmem_gnt = 1'b1; i_flush = 1'b1;
    tick;
    i_dmem_gnt = 1'b0; i_flush = 1'b0;
    checks++; if (o_mem_ready !== 1'b0) begin errors++; $display("FAIL flush at gnt drop: got %b exp 0", o_mem_ready); end
    i_dmem_rvalid = 1'b1;
    tick;
    i_dmem_rvalid = 1'b0;
    checks++; if (o_wb_valid !== 1'b0 || o_mem_ready !== 1'b1) begin errors++; $display("FAIL flush at gnt done: got %b/%b exp 0/1", o_wb_valid, o_mem_ready); end
  endtask

  task automatic test_reset_mid;
    drive_op(32'h00002023, 32'hA00, 32'h100, 32'h5A5A5A5A, 1'b1, 1'b0, 3'b010, 1'b0);
    tick;
    drive_idle;
    checks++; if (o_dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid req before: got %b exp 1", o_dmem_req); end
    i_reset_n = 1'b0;
    tick;
    checks++; if (o_dmem_req !== 1'b0 || o_mem_ready !== 1'b1 || o_wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid req/ready/valid: got %b/%b/%b exp 0/1/0", o_dmem_req, o_mem_ready, o_wb_valid); end
    checks++; if (o_dmem_be !== 4'b0000 || o_dmem_we !== 1'b0) begin errors++; $display("FAIL rstmid hold: got %b/%b exp 0000/0", o_dmem_be, o_dmem_we); end
    i_reset_n = 1'b1;
    drive_op(32'h00500093, 32'hB00, 32'h33, 32'h0, 1'b0, 1'b0, 3'b010, 1'b1);
    tick;
    drive_idle;
    checks++; if (o_wb_valid !== 1'b1 || o_wb_alu_data !== 32'h33) begin errors++; $display("FAIL rstmid resume: got %b/%h exp 1/33", o_wb_valid, o_wb_alu_data); end
  endtask

  initial begin
    i_reset_n = 1'b0;
    drive_idle;
    test_reset;
    test_alu;
    test_store;
    test_loads;
    test_same_cycle;
    test_misaligned;
    test_flush;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter NLANE, default XLEN/8, giving the number of byte lanes; it is derived and not overridden.
REQ-003 The block SHALL have port i_clk  in  1  sole clock; one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port i_reset_n  in  1  synchronous active-low reset.
REQ-005 The block SHALL have port i_flush  in  1  squash the instruction in MEM.
REQ-006 The block SHALL have ports i_mem_valid  in  1 and o_mem_ready  out  1  upstream valid/ready handshake.
REQ-007 The block SHALL have ports i_mem_inst  in  32 and i_mem_pc, i_mem_alu_data, i_mem_rs2_data  in  XLEN  instruction, PC, ALU result/address, store data.
REQ-008 The block SHALL have ports i_mem_lsu_wren, i_mem_lsu_rden  in  1, i_mem_slt_sl  in  3, i_mem_wb_sel  in  2 and i_mem_rd_wren  in  1  store/load/size/WB controls.
REQ-009 The block SHALL have ports o_dmem_req, o_dmem_we  out  1, o_dmem_addr, o_dmem_wdata  out  XLEN and o_dmem_be  out  NLANE  data-memory request.
REQ-010 The block SHALL have ports i_dmem_gnt, i_dmem_rvalid  in  1 and i_dmem_rdata  in  XLEN  data-memory grant and response.
REQ-011 The block SHALL have ports o_wb_valid, o_wb_rd_wren, o_wb_err  out  1, o_wb_wb_sel  out  2, o_wb_inst  out  32 and o_wb_pc_add4, o_wb_alu_data, o_wb_ld_data, o_wb_pc  out  XLEN  MEM/WB register.
REQ-012 The block SHALL have ports o_mem_rd_addr_fwd  out  5, o_mem_fwd_vld  out  1 and o_mem_stall  out  1  forwarding and hazard outputs.

Function
REQ-013 The FSM SHALL have states IDLE, REQ, RSP and DROP; o_mem_ready SHALL be 1 only in IDLE.
REQ-014 In IDLE, a transfer with i_mem_valid=1 that is neither a load nor a store SHALL be written to the WB register at the next edge (latency 1) with o_wb_valid=1.
REQ-015 An accepted aligned load or store SHALL be captured into hold registers, and the FSM SHALL go to REQ.
REQ-016 In REQ, o_dmem_req SHALL be 1 with o_dmem_addr/we/be/wdata stable until i_dmem_gnt=1.
REQ-017 On grant in REQ, a store SHALL write the WB register and return to IDLE; a load SHALL go to RSP.
REQ-018 In RSP, on i_dmem_rvalid=1 the load data SHALL be lane-selected, sign- or zero-extended per i_mem_slt_sl, written to o_wb_ld_data with o_wb_valid=1, and the FSM SHALL return to IDLE.
REQ-019 Byte enables SHALL be: byte = 1<<addr[log2(NLANE)-1:0]; half = 2'b11 shifted; word = 4'hF shifted; dword = all ones. Store data SHALL be replicated across lanes.
REQ-020 A misaligned access (half addr[0]!=0, word addr[1:0]!=0, dword addr[2:0]!=0), or a dword/lwu code with XLEN=32, SHALL issue no bus request and SHALL write WB with o_wb_err=1 and o_wb_rd_wren=0 at latency 1.
REQ-021 When o_wb_valid=0, o_wb_rd_wren SHALL be 0.
REQ-022 o_mem_stall SHALL equal the inverse of o_mem_ready.
REQ-023 o_mem_rd_addr_fwd SHALL be the held inst[11:7] when not in IDLE, else i_mem_inst[11:7].
REQ-024 o_mem_fwd_vld SHALL be 1 only in IDLE, when i_mem_valid=1, i_mem_rd_wren=1, and the instruction is not a load.
REQ-025 i_flush in IDLE SHALL discard the incoming instruction and write a bubble (o_wb_valid=0).
REQ-026 i_flush in REQ before grant SHALL drop o_dmem_req, write a bubble and return to IDLE.
REQ-027 i_flush in REQ at grant, or in RSP, SHALL go to DROP.
REQ-028 DROP SHALL wait for i_dmem_rvalid, discard it, write a bubble and return to IDLE.
REQ-029 When i_dmem_gnt and i_dmem_rvalid arrive in the same REQ cycle, the block SHALL complete the load in that cycle (REQ->IDLE).
REQ-030 o_wb_pc_add4 SHALL equal pc+4, wrapping modulo 2^XLEN.

Reset
REQ-031 On i_reset_n=0 at a clock edge, the FSM SHALL go to IDLE, and all WB outputs, hold registers, o_dmem_req and o_wb_err SHALL be 0. Reset SHALL take priority over flush and handshakes.
REQ-032 Reset mid-transaction SHALL abandon it; the block SHALL NOT assume or track a response still outstanding after reset is released.

Structure
REQ-033 The package mem_pkg SHALL hold the slt_sl encodings (LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110), the FSM state enum, and the load/store opcode constants.
REQ-034 A single sub-module, ld_align (combinational lane select and extend), SHALL be instantiated.

Verification
REQ-035 ALU op with i_mem_valid=1 and alu_data=32'h1234 -> next cycle o_wb_valid=1, o_wb_alu_data=32'h1234, o_wb_pc_add4=pc+4.
REQ-036 SB, addr=32'h103, rs2=32'hAB, gnt after 2 cycles -> o_dmem_be=4'b1000 and wdata=32'hABABABAB held stable throughout; o_mem_ready=0 until WB written.
REQ-037 LB, addr=32'h102, rdata=32'h0080_0000 -> o_wb_ld_data=32'hFFFF_FF80; the same case with LBU -> 32'h0000_0080.
REQ-038 LW, addr=32'h102 -> o_dmem_req never asserted, o_wb_err=1, o_wb_rd_wren=0, latency 1.
REQ-039 LW granted, i_flush in RSP, rvalid 3 cycles later -> DROP, then o_wb_valid=0 and IDLE; reset asserted mid-REQ -> IDLE with o_dmem_req=0 next edge.
